mem_arbiter: RTL and testbench

Arbitrates the single-port `sram` between the instruction-fetch path (PC-addressed reads) and the data-memory path (loads/stores), so one memory instance serves both. Sequences each access through a grant/access/respond FSM with a configurable number of wait states, and returns read data on a one-cycle valid pulse. Sits between the fetch/`pc_clk` logic and the load/store unit on one side and the `sram` `cs`/`oe`/`we`/`addr`/`din`/`dout` pins on the other.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: fetch vs. data path, grant/access/respond FSM with WAIT_STATES wait cycles.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    generate
        if (WAIT_STATES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
            $error("mem_arbiter: WAIT_STATES must be 0..15 and STARVE_LIMIT 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        wait_cnt;
    logic              any_req;
    logic              pick_dm;

    assign any_req = if_req || dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Fetch overrides fixed data priority once it has lost STARVE_LIMIT contested arbitrations.
    assign pick_dm = dm_req && !(if_req && (starve_cnt == 4'(STARVE_LIMIT)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            if (!pick_dm) begin
                starve_cnt <= '0;
            end else if (if_req && (starve_cnt != 4'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_dm  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_gnt <= 1'b0;
            dm_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_dm  <= pick_dm;
                        lat_we    <= pick_dm && dm_we;
                        lat_addr  <= pick_dm ? dm_addr : if_addr;
                        lat_wdata <= pick_dm ? dm_wdata : '0;
                        wait_cnt  <= 4'(WAIT_STATES);
                        if_gnt    <= !pick_dm;
                        dm_gnt    <= pick_dm;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (owner_dm) begin
                        dm_rdata <= lat_we ? '0 : mem_dout;
                    end else begin
                        if_rdata <= mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_cs   = 1'b0;
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if_valid = 1'b0;
        dm_valid = 1'b0;
        case (state)
            ACCESS: begin
                mem_cs   = 1'b1;
                mem_oe   = !lat_we;
                mem_we   = lat_we && (wait_cnt == 4'd0);
                mem_addr = lat_addr;
                mem_din  = lat_wdata;
            end
            DONE: begin
                if_valid = !owner_dm;
                dm_valid = owner_dm;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_STATES=1 main instance with an SRAM model, plus a WAIT_STATES=0 instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_valid, dm_gnt, dm_valid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    logic        z_if_req, z_dm_req, z_dm_we;
    logic [31:0] z_if_addr, z_dm_addr, z_dm_wdata;
    logic        z_if_gnt, z_if_valid, z_dm_gnt, z_dm_valid;
    logic [31:0] z_if_rdata, z_dm_rdata;
    logic        z_mem_cs, z_mem_oe, z_mem_we;
    logic [31:0] z_mem_addr, z_mem_din, z_mem_dout;

    logic [31:0] sram [0:1023];

    int unsigned passes = 0;
    int unsigned total  = 0;
    logic [1:0]  exp_g;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .STARVE_LIMIT(4)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_gnt(z_if_gnt), .if_valid(z_if_valid), .if_rdata(z_if_rdata),
        .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata),
        .dm_gnt(z_dm_gnt), .dm_valid(z_dm_valid), .dm_rdata(z_dm_rdata),
        .mem_cs(z_mem_cs), .mem_oe(z_mem_oe), .mem_we(z_mem_we),
        .mem_addr(z_mem_addr), .mem_din(z_mem_din), .mem_dout(z_mem_dout)
    );

    // SRAM model: async read, write on rising edge; preloaded while reset is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            sram[4]   <= 32'h8C22_0000;
            sram[264] <= 32'h0000_0000;
        end else if (mem_cs && mem_we) begin
            sram[mem_addr[9:0]] <= mem_din;
        end
    end
    assign mem_dout   = (mem_cs && mem_oe) ? sram[mem_addr[9:0]] : 32'h0;
    assign z_mem_dout = (z_mem_cs && z_mem_oe) ? (z_mem_addr ^ 32'hA5A5_0000) : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        z_if_req = 0; z_if_addr = 0; z_dm_req = 0; z_dm_we = 0; z_dm_addr = 0; z_dm_wdata = 0;
        step(); step();
        chk("rst_gnt",   {30'd0, if_gnt, dm_gnt}, 32'd0);
        chk("rst_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        chk("rst_mem",   {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Fetch of word 0x4
        if_req = 1; if_addr = 32'h4;
        step();
        chk("f_gnt_c1",  {30'd0, if_gnt, dm_gnt}, 32'd2);
        chk("f_mem_c1",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd6);
        chk("f_addr_c1", mem_addr, 32'h4);
        step();
        chk("f_gnt_c2",  {30'd0, if_gnt, dm_gnt}, 32'd0);
        chk("f_oe_c2",   {31'd0, mem_oe}, 32'd1);
        chk("f_val_c2",  {31'd0, if_valid}, 32'd0);
        step();
        chk("f_val_c3",  {30'd0, if_valid, dm_valid}, 32'd2);
        chk("f_rdata",   if_rdata, 32'h8C22_0000);
        chk("f_mem_c3",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        if_req = 0;
        step();
        chk("f_val_c4",  {31'd0, if_valid}, 32'd0);
        chk("f_hold",    if_rdata, 32'h8C22_0000);

        // Store 0xDEADBEEF to 0x100
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("s_gnt_c1",  {30'd0, if_gnt, dm_gnt}, 32'd1);
        chk("s_mem_c1",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd4);
        chk("s_din_c1",  mem_din, 32'hDEAD_BEEF);
        step();
        chk("s_mem_c2",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd5);
        chk("s_addr_c2", mem_addr, 32'h100);
        step();
        chk("s_we_c3",   {31'd0, mem_we}, 32'd0);
        chk("s_val_c3",  {30'd0, if_valid, dm_valid}, 32'd1);
        chk("s_rdata",   dm_rdata, 32'd0);
        dm_req = 0;
        step();

        // Load back 0x100
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        step();
        chk("l_gnt_c1",  {30'd0, if_gnt, dm_gnt}, 32'd1);
        step();
        chk("l_mem_c2",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd6);
        step();
        chk("l_val_c3",  {30'd0, if_valid, dm_valid}, 32'd1);
        chk("l_rdata",   dm_rdata, 32'hDEAD_BEEF);
        chk("l_if_hold", if_rdata, 32'h8C22_0000);
        dm_req = 0;
        step();

        // Second store clears dm_rdata
        dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'h1234_5678;
        step(); step();
        chk("s2_we_c2",  {31'd0, mem_we}, 32'd1);
        step();
        chk("s2_val",    {31'd0, dm_valid}, 32'd1);
        chk("s2_rdata",  dm_rdata, 32'd0);
        dm_req = 0;
        step();

        // Simultaneous requests: data first, then fetch after DONE + IDLE
        if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        step();
        chk("b_gnt_c1",  {30'd0, if_gnt, dm_gnt}, 32'd1);
        step(); step();
        chk("b_val_c3",  {30'd0, if_valid, dm_valid}, 32'd1);
        chk("b_drd_c3",  dm_rdata, 32'hDEAD_BEEF);
        dm_req = 0;
        step();
        chk("b_idle_c4", {30'd0, if_gnt, dm_gnt}, 32'd0);
        step();
        chk("b_gnt_c5",  {30'd0, if_gnt, dm_gnt}, 32'd2);
        step(); step();
        chk("b_val_c7",  {30'd0, if_valid, dm_valid}, 32'd2);
        chk("b_ird_c7",  if_rdata, 32'h8C22_0000);
        if_req = 0;
        step();

        // Data port held with fetch pending across five arbitrations
        if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        for (int unsigned k = 0; k < 5; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_g = (k == 2) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            step();
            chk($sformatf("st_gnt_%0d", k), {30'd0, if_gnt, dm_gnt}, {30'd0, exp_g});
            step(); step();
            chk($sformatf("st_val_%0d", k), {30'd0, if_valid, dm_valid}, {30'd0, exp_g});
            step();
        end
        if_req = 0; dm_req = 0;
        step();

        // Reset during the ACCESS phase of a store to 0x108
        dm_req = 1; dm_we = 1; dm_addr = 32'h108; dm_wdata = 32'h55AA_55AA;
        step();
        chk("r_gnt_c1",  {30'd0, if_gnt, dm_gnt}, 32'd1);
        rst_n = 1'b0;
        step();
        dm_req = 0;
        chk("r_mem_c2",  {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        chk("r_out_c2",  {28'd0, if_gnt, dm_gnt, if_valid, dm_valid}, 32'd0);
        chk("r_rd_c2",   if_rdata | dm_rdata, 32'd0);
        step();
        chk("r_out_c3",  {29'd0, dm_valid, mem_we, mem_cs}, 32'd0);
        rst_n = 1'b1;
        step();
        dm_req = 1; dm_we = 0; dm_addr = 32'h108;
        step(); step(); step();
        chk("r_ld_val",  {31'd0, dm_valid}, 32'd1);
        chk("r_ld_data", dm_rdata, 32'd0);
        dm_req = 0;
        step();

        // WAIT_STATES=0: fetch then store
        z_if_req = 1; z_if_addr = 32'h20;
        step();
        chk("z_gnt_c1",  {30'd0, z_if_gnt, z_dm_gnt}, 32'd2);
        chk("z_mem_c1",  {29'd0, z_mem_cs, z_mem_oe, z_mem_we}, 32'd6);
        step();
        chk("z_val_c2",  {30'd0, z_if_valid, z_dm_valid}, 32'd2);
        chk("z_rdata",   z_if_rdata, 32'hA5A5_0020);
        z_if_req = 0;
        step();
        z_dm_req = 1; z_dm_we = 1; z_dm_addr = 32'h30; z_dm_wdata = 32'hCAFE_F00D;
        step();
        chk("zs_mem_c1", {29'd0, z_mem_cs, z_mem_oe, z_mem_we}, 32'd5);
        chk("zs_din_c1", z_mem_din, 32'hCAFE_F00D);
        step();
        chk("zs_val_c2", {30'd0, z_dm_valid, z_mem_we}, 32'd2);
        chk("zs_rdata",  z_dm_rdata, 32'd0);
        z_dm_req = 0;
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
